// File: rtl/owire_pkg.sv
// -----------------------------------------------------------------------------
// owire_pkg
// Shared types and timing constants for the 1-Wire master PHY.
//   owire_cmd_t    : command encoding presented on the 3-bit cmd port
//   owire_state_t  : bit/byte engine FSM states
//   T_*            : slot timing in microseconds (10-bit, matches the us counter)
//   cmd_is_*       : small decode helpers shared by the datapath and the FSM
// -----------------------------------------------------------------------------
package owire_pkg;

  typedef enum logic [2:0] {
    CMD_NONE       = 3'd0,
    CMD_RESET      = 3'd1,
    CMD_WRITE_BYTE = 3'd2,
    CMD_READ_BYTE  = 3'd3,
    CMD_WRITE_BIT  = 3'd4,
    CMD_READ_BIT   = 3'd5
  } owire_cmd_t;

  // Bit 3 of the encoding is set only in the two states that pull the bus low,
  // so ow_out comes straight off one flop and cannot glitch between states.
  typedef enum logic [3:0] {
    ST_IDLE      = 4'b0000,
    ST_RST_WAIT  = 4'b0001,
    ST_RST_REC   = 4'b0010,
    ST_SLOT_HOLD = 4'b0011,
    ST_SLOT_REC  = 4'b0100,
    ST_DONE      = 4'b0101,
    ST_WAIT_REL  = 4'b0110,
    ST_RST_LOW   = 4'b1000,
    ST_SLOT_LOW  = 4'b1001
  } owire_state_t;

  localparam logic [9:0] T_RST_LOW     = 10'd480;
  localparam logic [9:0] T_PRES_SAMPLE = 10'd70;
  localparam logic [9:0] T_RST_REC     = 10'd480;
  localparam logic [9:0] T_W1_LOW      = 10'd6;
  localparam logic [9:0] T_W0_LOW      = 10'd60;
  localparam logic [9:0] T_SLOT        = 10'd64;
  localparam logic [9:0] T_REC         = 10'd10;
  localparam logic [9:0] T_RD_SAMPLE   = 10'd13;

  function automatic logic cmd_is_legal(input logic [2:0] c);
    return (c >= CMD_RESET) && (c <= CMD_READ_BIT);
  endfunction

  function automatic logic cmd_is_read(input logic [2:0] c);
    return (c == CMD_READ_BYTE) || (c == CMD_READ_BIT);
  endfunction

  function automatic logic cmd_is_byte(input logic [2:0] c);
    return (c == CMD_WRITE_BYTE) || (c == CMD_READ_BYTE);
  endfunction

endpackage

// File: rtl/owire_tick.sv
// -----------------------------------------------------------------------------
// owire_tick
// Microsecond prescaler: one-cycle strobe every CLK_FREQ_HZ/1e6 clocks.
//   CLK_FREQ_HZ : system clock frequency (integer multiple of 1 MHz, >= 4 MHz)
//   clk, reset  : system clock, asynchronous active-high reset
//   tick        : registered 1 us strobe
// -----------------------------------------------------------------------------
module owire_tick #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + CW'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/owire_master_phy.sv
// -----------------------------------------------------------------------------
// owire_master_phy
// 1-Wire bit/byte engine: turns a 3-bit command into reset, write and read
// time slots on the open-drain dq line and reports data/presence/error with a
// done pulse and a sticky irq.
//   clk, reset : system clock, asynchronous active-high reset
//   ow_in      : raw dq level (asynchronous)
//   ow_out     : 1 = release dq, 0 = pull low
//   cmd        : 0 none, 1 reset, 2 wr byte, 3 rd byte, 4 wr bit, 5 rd bit
//   bus_in     : write data (bit 0 for write bit)
//   bus_out    : read data, updated at completion of read commands only
//   presence   : result of the last reset pulse
//   error      : status of the last command
//   done       : one-cycle completion pulse
//   irq        : set with done, cleared by clear
//   clear      : clears irq, error and presence (a simultaneous set wins)
// Optional build macro: OWIRE_GLITCH_FILTER_EN adds a 3-sample majority filter,
// clocked by the us tick, behind the synchronizer; sample points move 2 us
// earlier to cancel its latency.
// -----------------------------------------------------------------------------
module owire_master_phy
  import owire_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ow_in,
  output logic       ow_out,
  input  logic [2:0] cmd,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       presence,
  output logic       error,
  output logic       done,
  output logic       irq,
  input  logic       clear
);

  logic tick;

  owire_tick #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Input conditioning: the released bus idles high, so reset to 1s.
  logic [1:0] sync_q;
  logic       line;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], ow_in};
  end

`ifdef OWIRE_GLITCH_FILTER_EN
  localparam logic [9:0] SAMPLE_ADJ = 10'd2;
  logic [2:0] filt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     filt_q <= 3'b111;
    else if (tick) filt_q <= {filt_q[1:0], sync_q[1]};
  end

  assign line = (filt_q[0] & filt_q[1]) | (filt_q[0] & filt_q[2]) |
                (filt_q[1] & filt_q[2]);
`else
  localparam logic [9:0] SAMPLE_ADJ = 10'd0;
  assign line = sync_q[1];
`endif

  // Sample strobes fire on the tick that ends the given microsecond.
  localparam logic [9:0] PRES_AT = T_PRES_SAMPLE - 10'd1 - SAMPLE_ADJ;
  localparam logic [9:0] RD_AT   = T_RD_SAMPLE - 10'd1 - SAMPLE_ADJ;

  owire_state_t state, state_next;
  logic [9:0]   us_cnt;
  logic [2:0]   cmd_q;
  logic [7:0]   sr;
  logic [3:0]   bit_cnt;
  logic         err_q;
  logic         is_read;
  logic [9:0]   low_len;

  logic cnt_clr, load, pres_smp, rd_smp, bit_adv, err_set;

  assign is_read = cmd_is_read(cmd_q);
  // Read slots and write-1 slots share the short low pulse.
  assign low_len = (is_read || sr[0]) ? T_W1_LOW : T_W0_LOW;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state and datapath strobes. The us counter runs from slot start
  // through SLOT_LOW/SLOT_HOLD and from release through RST_WAIT/RST_REC, so
  // only phase boundaries clear it. Every transition after the first lands on
  // a tick, which keeps the tick jitter to the first interval only.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_next = state;
    cnt_clr    = 1'b0;
    load       = 1'b0;
    pres_smp   = 1'b0;
    rd_smp     = 1'b0;
    bit_adv    = 1'b0;
    err_set    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd != CMD_NONE) begin
          load    = 1'b1;
          cnt_clr = 1'b1;
          if (cmd == CMD_RESET)     state_next = ST_RST_LOW;
          else if (cmd_is_legal(cmd)) state_next = ST_SLOT_LOW;
          else                      state_next = ST_DONE;
        end
      end
      ST_RST_LOW: begin
        if (tick && us_cnt == T_RST_LOW - 10'd1) begin
          state_next = ST_RST_WAIT;
          cnt_clr    = 1'b1;
        end
      end
      ST_RST_WAIT: begin
        if (tick && us_cnt == PRES_AT) begin
          state_next = ST_RST_REC;
          pres_smp   = 1'b1;
        end
      end
      ST_RST_REC: begin
        if (tick && us_cnt == T_RST_REC - 10'd1) begin
          state_next = ST_DONE;
          err_set    = ~line;
        end
      end
      ST_SLOT_LOW: begin
        if (tick && us_cnt == low_len - 10'd1) state_next = ST_SLOT_HOLD;
      end
      ST_SLOT_HOLD: begin
        rd_smp = is_read && tick && (us_cnt == RD_AT);
        if (tick && us_cnt == T_SLOT - 10'd1) begin
          state_next = ST_SLOT_REC;
          cnt_clr    = 1'b1;
        end
      end
      ST_SLOT_REC: begin
        if (tick && us_cnt == T_REC - 10'd1) begin
          cnt_clr = 1'b1;
          if (!line) begin
            // Bus stuck low: abort the remaining bits.
            err_set    = 1'b1;
            state_next = ST_DONE;
          end else begin
            bit_adv    = 1'b1;
            state_next = (bit_cnt == 4'd1) ? ST_DONE : ST_SLOT_LOW;
          end
        end
      end
      ST_DONE:     state_next = ST_WAIT_REL;
      ST_WAIT_REL: if (cmd == CMD_NONE) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state: only the drive-low flag.
  always_comb begin
    ow_out = ~state[3];
  end

  // Timing counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        us_cnt <= '0;
    else if (cnt_clr) us_cnt <= '0;
    else if (tick)    us_cnt <= us_cnt + 10'd1;
  end

  // Command datapath: captured once, so later cmd/bus_in changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q   <= CMD_NONE;
      sr      <= '0;
      bit_cnt <= '0;
      err_q   <= 1'b0;
    end else if (load) begin
      cmd_q   <= cmd;
      sr      <= bus_in;
      bit_cnt <= cmd_is_byte(cmd) ? 4'd8 : 4'd1;
      err_q   <= ~cmd_is_legal(cmd);
    end else begin
      if (err_set) err_q <= 1'b1;
      // Reads shift the sample in at the MSB; writes consume bit 0 per slot.
      if (rd_smp) sr <= {line, sr[7:1]};
      else if (bit_adv && !is_read) sr <= {1'b0, sr[7:1]};
      if (bit_adv) bit_cnt <= bit_cnt - 4'd1;
    end
  end

  // Status and handshake. All completion results appear together with done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done     <= 1'b0;
      irq      <= 1'b0;
      error    <= 1'b0;
      bus_out  <= '0;
      presence <= 1'b0;
    end else begin
      done <= (state == ST_DONE);
      if (state == ST_DONE) begin
        irq   <= 1'b1;
        error <= err_q;
        if (is_read) bus_out <= sr;
      end else if (clear) begin
        irq   <= 1'b0;
        error <= 1'b0;
      end
      if (pres_smp)   presence <= ~line;
      else if (clear) presence <= 1'b0;
    end
  end

endmodule

// File: doc/owire_master_phy.md
# owire_master_phy

1-Wire bit/byte engine: converts the 3-bit command word from the protocol and device layers into reset, write and read time slots on the open-drain `dq` line. It returns the read byte, presence and error status with a done/irq handshake. It sits directly downstream of the protocol/device command mux, and its `ow_out` drives the tristate `dq = ow_out ? Z : 0`.

## Interface
- `CLK_FREQ_HZ`, 50_000_000, system clock frequency; must be an integer multiple of 1 MHz, ≥ 4 MHz.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ow_in`  in  1  raw `dq` level; asynchronous.
- `ow_out`  out  1  1 = release the line, 0 = pull low.
- `cmd`  in  3  0 none, 1 reset, 2 write byte, 3 read byte, 4 write bit, 5 read bit, 6–7 illegal.
- `bus_in`  in  8  write data; bit 0 is used for write bit.
- `bus_out`  out  8  read data; for read bit, the value lands in bit 7 (shifted in MSB-side, LSB-first).
- `presence`  out  1  result of the last reset; 1 = device answered.
- `error`  out  1  status of the last command.
- `done`  out  1  one-cycle pulse when a command completes.
- `irq`  out  1  level; set with `done`, cleared by `clear`.
- `clear`  in  1  clears `irq`, `error` and `presence`.

## Operation
- The µs tick is a one-cycle strobe every CLK_FREQ_HZ/1e6 clocks. All slot timing is counted in ticks with a 10-bit µs counter.
- `ow_in` passes through a 2-flop synchronizer. Sample points below are nominal; sync latency counts inside the margin.
- FSM states: IDLE, RST_LOW, RST_WAIT, RST_REC, SLOT_LOW, SLOT_HOLD, SLOT_REC, DONE, WAIT_REL.
- IDLE: `ow_out`=1. A nonzero `cmd` is captured with `bus_in`, and the bit count is loaded (8 or 1).
  - An illegal `cmd` goes directly to DONE with `error`=1.
- Reset command:
  - RST_LOW drives low for 480 µs.
  - RST_WAIT releases the line and samples at 70 µs. `presence` = !line.
  - RST_REC waits until 480 µs after release.
  - If the line is still low at the end of RST_REC, `error`=1.
- Write bit:
  - SLOT_LOW drives low 6 µs for a 1, or 60 µs for a 0.
  - SLOT_HOLD releases until 64 µs after the slot start.
  - SLOT_REC releases for a further 10 µs.
- Read bit:
  - SLOT_LOW drives low 6 µs, then releases.
  - Sample at 13 µs from slot start. The sample is shifted into the MSB of the shift register, which is right-shifted.
  - Remainder of the slot matches the write-bit timing.
- Bytes are sent LSB first.
- If the line is low at the end of SLOT_REC, the slot is stuck: `error`=1 and the remaining bits are aborted.
- DONE:
  - Pulse `done` for one cycle and set `irq`.
  - `bus_out` is updated here only, and only for read commands.
  - `error` is updated for every command.
- WAIT_REL: hold until `cmd`==0, then go to IDLE. This prevents a level-held command from re-triggering.
- `clear`:
  - Clears `irq`/`error`/`presence` in any state.
  - If asserted in the same cycle DONE sets them, the set wins.
  - It does not abort an active command.

## Timing
- Reset values: `ow_out`=1, `bus_out`=0, `presence`=0, `error`=0, `done`=0, `irq`=0. FSM resets to IDLE and the tick counter to 0.
- Reset mid-slot releases the line within one clock. The same applies to reset mid-`clear`.
- Command capture to the first `ow_out` low edge: 1 clock.
- Durations (±1 µs tick jitter, since the first tick is asynchronous to command capture):
  - Reset: 960 µs.
  - Bit slot: 74 µs.
  - Byte: 592 µs.
- `done` falls 1 clock after rising. `irq` is held until `clear`.
- `cmd` changes during a command are ignored.

## Configuration
- `OWIRE_GLITCH_FILTER_EN`: when defined, a 3-sample majority filter sits on the synchronized input, clocked by the µs tick.
  - Adds ≤2 µs latency; sample points move 2 µs earlier to compensate.
  - When undefined, the synchronizer output is used directly.

## Structure
- `owire_pkg`:
  - `owire_cmd_t` enum (NONE, RESET, WRITE_BYTE, READ_BYTE, WRITE_BIT, READ_BIT).
  - FSM state enum.
  - µs timing constants: T_RST_LOW 480, T_PRES_SAMPLE 70, T_RST_REC 480, T_W1_LOW 6, T_W0_LOW 60, T_SLOT 64, T_REC 10, T_RD_SAMPLE 13.
- Sub-module `owire_tick`: the µs prescaler, parameterized by CLK_FREQ_HZ.

## Test plan
- Reset with a device model pulling low from 15–135 µs after release → `ow_out` low for 480 µs, then `done`; `presence`=1, `error`=0, `irq`=1.
- Reset with no device → `presence`=0, `error`=0, `done` after ≈960 µs.
- Write byte `bus_in`=8'hA5 → low pulses in order 6,60,6,60,60,6,60,6 µs (LSB first), `done` once.
- Read byte, device returns 8'h3C → `bus_out`=8'h3C at `done`. Then assert `clear` → `irq`=0.
- Hold `dq` low externally during a write byte → `error`=1 after the first slot, `done` without further slots.
- `cmd`=7 → `done` in ≤3 clocks with `error`=1 and no `ow_out` activity. Holding `cmd` at 2 after `done` → no second transaction until `cmd`=0.
